// File: rtl/ctrl_pool_stride.sv
// Raster tracker that generates line-buffer and pool start/valid/stop for a strided pooling stage.
// Bus bit order is {stop, valid, start}. Define CTRL_POOL_CFG_CHECK_EN to add the cfg_err port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_WAIT   | idle, counters cleared, waiting for in_ctrl start
// S_ACTIVE | frame in progress, held until the delayed stop reaches out_ctrl
module ctrl_pool_stride #(
    parameter int LWIDTH    = 10,
    parameter int D_POOLBUF = 1026,
    parameter int D_POOL    = 2,
    parameter int SWIDTH    = 2
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic [2:0]        in_ctrl,
    input  logic [LWIDTH-1:0] fea_w,
    input  logic [LWIDTH-1:0] fea_h,
    input  logic [LWIDTH-1:0] pool_size,
    input  logic [SWIDTH-1:0] stride_log2,
    output logic              buf_feat_en,
    output logic [2:0]        out_ctrl,
    output logic              pool_oe,
    output logic [LWIDTH-1:0] w_pool_size,
    output logic [LWIDTH-1:0] w_out_w,
    output logic [LWIDTH-1:0] w_out_h
`ifdef CTRL_POOL_CFG_CHECK_EN
    ,
    output logic              cfg_err
`endif
);

    localparam int DW = $clog2(D_POOLBUF);

    typedef enum logic {
        S_WAIT   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic              in_start, in_valid;
    logic              unused_in_stop;
    logic              start_cfg, cfg_bad, adv;
    logic [LWIDTH-1:0] r_fea_w, r_fea_h;
    logic [SWIDTH-1:0] r_stride_log2;
    logic [DW-1:0]     r_delay;
    logic [LWIDTH-1:0] x, y, px, py, stride_mask;
    logic              x_last, y_last, x_win0, y_win0;
    logic              ev_start, ev_valid, ev_stop;
    logic [2:0]        dly [D_POOLBUF];
    logic [2:0]        pipe [D_POOL];
    logic [2:0]        pool_ctrl;

    assign in_start       = in_ctrl[0];
    assign in_valid       = in_ctrl[1];
    // Frame end comes from the position counters, so the upstream stop is not needed.
    assign unused_in_stop = in_ctrl[2];

    assign start_cfg = (state == S_WAIT) && in_start;

`ifdef CTRL_POOL_CFG_CHECK_EN
    assign cfg_bad = (pool_size < LWIDTH'(2)) || (pool_size > fea_w) || (pool_size > fea_h)
                   || ((32'd1 << stride_log2) > 32'(pool_size));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst)          cfg_err <= 1'b0;
        else if (start_cfg) cfg_err <= cfg_bad;
    end
`else
    assign cfg_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) state <= S_WAIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:   if (in_start && !cfg_bad) state_nxt = S_ACTIVE;
            S_ACTIVE: if (out_ctrl[2])          state_nxt = S_WAIT;
            default:                            state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_fea_w       <= '0;
            r_fea_h       <= '0;
            r_stride_log2 <= '0;
            r_delay       <= '0;
            w_pool_size   <= '0;
            w_out_w       <= '0;
            w_out_h       <= '0;
        end else if (start_cfg) begin
            r_fea_w       <= fea_w;
            r_fea_h       <= fea_h;
            r_stride_log2 <= stride_log2;
            r_delay       <= DW'(fea_w) + DW'(2);
            w_pool_size   <= pool_size;
            w_out_w       <= ((fea_w - pool_size) >> stride_log2) + LWIDTH'(1);
            w_out_h       <= ((fea_h - pool_size) >> stride_log2) + LWIDTH'(1);
        end
    end

    assign adv         = (state == S_ACTIVE) && in_valid;
    assign stride_mask = (LWIDTH'(1) << r_stride_log2) - LWIDTH'(1);
    assign x_last      = (x == r_fea_w - LWIDTH'(1));
    assign y_last      = (y == r_fea_h - LWIDTH'(1));
    assign x_win0      = (x == w_pool_size - LWIDTH'(1));
    assign y_win0      = (y == w_pool_size - LWIDTH'(1));

    // px/py hold the stride phase of the current column/row relative to the first full window.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            x  <= '0;
            y  <= '0;
            px <= '0;
            py <= '0;
        end else if (state == S_WAIT) begin
            x  <= '0;
            y  <= '0;
            px <= '0;
            py <= '0;
        end else if (in_valid) begin
            if (x_last) begin
                x  <= '0;
                px <= '0;
                if (y_last) begin
                    y  <= '0;
                    py <= '0;
                end else begin
                    y  <= y + LWIDTH'(1);
                    py <= y_win0 ? (LWIDTH'(1) & stride_mask) : ((py + LWIDTH'(1)) & stride_mask);
                end
            end else begin
                x  <= x + LWIDTH'(1);
                px <= x_win0 ? (LWIDTH'(1) & stride_mask) : ((px + LWIDTH'(1)) & stride_mask);
            end
        end
    end

    assign ev_start = adv && (x == w_pool_size - LWIDTH'(2)) && y_win0;
    assign ev_valid = adv && (x >= w_pool_size - LWIDTH'(1)) && (y >= w_pool_size - LWIDTH'(1))
                   && ((px == '0) || x_win0) && ((py == '0) || y_win0);
    assign ev_stop  = adv && x_last && y_last;

    // dly[0] is the registered stage-0 event; dly[i] lags it by i cycles.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < D_POOLBUF; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {ev_stop, ev_valid, ev_start};
            for (int i = 1; i < D_POOLBUF; i++) dly[i] <= dly[i-1];
        end
    end

    assign pool_ctrl = (32'(r_delay) < D_POOLBUF) ? dly[r_delay] : 3'b000;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < D_POOL; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= pool_ctrl;
            for (int i = 1; i < D_POOL; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign out_ctrl = pipe[D_POOL-1];
    assign pool_oe  = pipe[D_POOL-2][1];

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) buf_feat_en <= 1'b0;
        else       buf_feat_en <= in_start;
    end

endmodule

// File: tb/tb_ctrl_pool_stride.sv
// Bench for ctrl_pool_stride: per-pixel window model with a per-cycle compare of out_ctrl/pool_oe/buf_feat_en.
module tb_ctrl_pool_stride;

    localparam int LW   = 10;
    localparam int DPB  = 1026;
    localparam int DP   = 2;
    localparam int SW   = 2;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          xrst;
    logic [2:0]    in_ctrl;
    logic [LW-1:0] fea_w, fea_h, pool_size;
    logic [SW-1:0] stride_log2;
    logic          buf_feat_en, pool_oe;
    logic [2:0]    out_ctrl;
    logic [LW-1:0] w_pool_size, w_out_w, w_out_h;
`ifdef CTRL_POOL_CFG_CHECK_EN
    logic          cfg_err;
`endif

    ctrl_pool_stride #(.LWIDTH(LW), .D_POOLBUF(DPB), .D_POOL(DP), .SWIDTH(SW)) dut (
        .clk(clk), .xrst(xrst), .in_ctrl(in_ctrl),
        .fea_w(fea_w), .fea_h(fea_h), .pool_size(pool_size), .stride_log2(stride_log2),
        .buf_feat_en(buf_feat_en), .out_ctrl(out_ctrl), .pool_oe(pool_oe),
        .w_pool_size(w_pool_size), .w_out_w(w_out_w), .w_out_h(w_out_h)
`ifdef CTRL_POOL_CFG_CHECK_EN
        , .cfg_err(cfg_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] exp_out [MAXC];
    logic       exp_oe  [MAXC];
    logic       exp_bfe [MAXC];

    int checks = 0;
    int errors = 0;
    int nvalid, nstart, nstop, stop_cyc, first_valid_cyc;
    int last_pix_n, pix22_n;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("out_ctrl", 32'(out_ctrl), 32'(exp_out[cyc]));
            chk("pool_oe", 32'(pool_oe), 32'(exp_oe[cyc]));
            chk("buf_feat_en", 32'(buf_feat_en), 32'(exp_bfe[cyc]));
            if (out_ctrl[0]) nstart++;
            if (out_ctrl[1]) begin
                nvalid++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_ctrl[2]) begin
                nstop++;
                stop_cyc = cyc;
            end
        end
    end

    task automatic step(input logic st, input logic vl);
        in_ctrl = {1'b0, vl, st};
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid();
        in_ctrl = 3'b000;
        xrst = 1'b0;
        #1;
        chk("midrst out_ctrl", 32'(out_ctrl), 32'd0);
        chk("midrst pool_oe", 32'(pool_oe), 32'd0);
        chk("midrst buf_feat_en", 32'(buf_feat_en), 32'd0);
        chk("midrst w_out_w", 32'(w_out_w), 32'd0);
        chk("midrst w_out_h", 32'(w_out_h), 32'd0);
        chk("midrst w_pool_size", 32'(w_pool_size), 32'd0);
        for (int i = cyc; i < MAXC; i++) begin
            exp_out[i] = 3'b000;
            exp_oe[i]  = 1'b0;
            exp_bfe[i] = 1'b0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        xrst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // Window rule: a pixel closes a window when it is at pool-1 + k*stride in both axes.
    task automatic run_frame(input int fw, input int fh, input int ps, input int sl,
                             input int gap_every, input int spur_at, input int abort_at,
                             input bit legal, input int exp_ow, input int exp_oh);
        int s, lat, beats, n;
        bit aborted;
        s   = 1 << sl;
        lat = 1 + (fw + 2) + DP;
        nvalid = 0; nstart = 0; nstop = 0; stop_cyc = -1; first_valid_cyc = -1;
        fea_w = LW'(fw); fea_h = LW'(fh); pool_size = LW'(ps); stride_log2 = SW'(sl);
        exp_bfe[cyc+1] = 1'b1;
        step(1'b1, 1'b0);
        if (legal) begin
            chk("w_out_w", 32'(w_out_w), exp_ow);
            chk("w_out_h", 32'(w_out_h), exp_oh);
            chk("w_pool_size", 32'(w_pool_size), ps);
        end
        beats = 0;
        aborted = 1'b0;
        for (int y = 0; y < fh && !aborted; y++) begin
            for (int x = 0; x < fw && !aborted; x++) begin
                if (beats == abort_at) begin
                    reset_mid();
                    aborted = 1'b1;
                end else begin
                    if (gap_every > 0 && beats > 0 && (beats % gap_every) == 0) step(1'b0, 1'b0);
                    if (beats == spur_at) begin
                        fea_w = LW'(fw - 3);
                        exp_bfe[cyc+1] = 1'b1;
                        step(1'b1, 1'b0);
                    end
                    n = cyc;
                    if (legal && (n + lat) < MAXC) begin
                        if (x == ps - 2 && y == ps - 1) exp_out[n+lat][0] = 1'b1;
                        if (x >= ps - 1 && y >= ps - 1 && ((x - ps + 1) % s) == 0 && ((y - ps + 1) % s) == 0) begin
                            exp_out[n+lat][1] = 1'b1;
                            exp_oe[n+lat-1]   = 1'b1;
                        end
                        if (x == fw - 1 && y == fh - 1) exp_out[n+lat][2] = 1'b1;
                    end
                    if (x == 2 && y == 2) pix22_n = n;
                    last_pix_n = n;
                    step(1'b0, 1'b1);
                    beats++;
                end
            end
        end
        if (aborted) return;
        if (legal) begin
            for (int i = 0; i < lat + 50 && nstop == 0; i++) step(1'b0, 1'b0);
            chk("stop seen", nstop, 1);
        end else begin
            repeat (20) step(1'b0, 1'b0);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_out[i] = 3'b000;
            exp_oe[i]  = 1'b0;
            exp_bfe[i] = 1'b0;
        end
        xrst = 1'b1;
        in_ctrl = 3'b000;
        fea_w = '0; fea_h = '0; pool_size = '0; stride_log2 = '0;
        #1 xrst = 1'b0;
        #1;
        chk("reset out_ctrl", 32'(out_ctrl), 32'd0);
        chk("reset pool_oe", 32'(pool_oe), 32'd0);
        chk("reset buf_feat_en", 32'(buf_feat_en), 32'd0);
        chk("reset w_out_w", 32'(w_out_w), 32'd0);
        chk("reset w_out_h", 32'(w_out_h), 32'd0);
        chk("reset w_pool_size", 32'(w_pool_size), 32'd0);
`ifdef CTRL_POOL_CFG_CHECK_EN
        chk("reset cfg_err", 32'(cfg_err), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1 xrst = 1'b1;
        step(1'b0, 1'b0);

        // 8x8, pool 2, stride 2
        run_frame(8, 8, 2, 1, 0, -1, -1, 1'b1, 4, 4);
        chk("t1 valids", nvalid, 16);
        chk("t1 starts", nstart, 1);
        chk("t1 stops", nstop, 1);
        chk("t1 stop latency", stop_cyc - last_pix_n, 13);

        // 12x6, pool 3, stride 1
        run_frame(12, 6, 3, 0, 0, -1, -1, 1'b1, 10, 4);
        chk("t2 valids", nvalid, 40);
        chk("t2 first valid latency", first_valid_cyc - pix22_n, 17);
        chk("t2 stop latency", stop_cyc - last_pix_n, 17);

        // 8x8, pool 4, stride 2, with an ignored start mid-frame
        run_frame(8, 8, 4, 1, 0, 30, -1, 1'b1, 3, 3);
        chk("t3 valids", nvalid, 9);
        chk("t3 starts", nstart, 1);
        chk("t3 w_out_w kept", 32'(w_out_w), 32'd3);

        // 8x8, pool 2, stride 2, gap after every 3rd beat
        run_frame(8, 8, 2, 1, 3, -1, -1, 1'b1, 4, 4);
        chk("t4 valids", nvalid, 16);
        chk("t4 stop latency", stop_cyc - last_pix_n, 13);

        // reset at pixel 20, then a fresh 4x4 frame
        run_frame(8, 8, 2, 1, 0, -1, 20, 1'b1, 4, 4);
        chk("t5 no stop", nstop, 0);
        run_frame(4, 4, 2, 1, 0, -1, -1, 1'b1, 2, 2);
        chk("t5 valids", nvalid, 4);
        chk("t5 stop latency", stop_cyc - last_pix_n, 9);

`ifdef CTRL_POOL_CFG_CHECK_EN
        run_frame(8, 8, 4, 3, 0, -1, -1, 1'b0, 0, 0);
        chk("t6 cfg_err set", 32'(cfg_err), 32'd1);
        chk("t6 no valids", nvalid, 0);
        chk("t6 no starts", nstart, 0);
        chk("t6 no stops", nstop, 0);
        run_frame(4, 4, 2, 1, 0, -1, -1, 1'b1, 2, 2);
        chk("t6 cfg_err cleared", 32'(cfg_err), 32'd0);
        chk("t6 valids", nvalid, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
